// File: rtl/sobel_window_linebuffer.sv
`default_nettype none
// ============================================================================
//  Module   : sobel_window_linebuffer
//  Purpose  : Line buffer in front of the Sobel/demosaic window registers.
//             Consumes one pixel per transfer from an FWFT FIFO, keeps the
//             NUM_ROWS-1 previous lines in cascaded line RAMs and emits one
//             vertically aligned column of NUM_ROWS pixels per transfer,
//             tagged with the (x, y) position of the newest pixel.
//  Ports    : clk, rst_n      - clock, asynchronous active-low reset
//             clr             - synchronous frame restart (one-cycle pulse)
//             fifo_nempty     - upstream FIFO holds a pixel
//             fifo_re         - upstream read strobe (combinational)
//             fifo_din        - upstream pixel, consumed with fifo_re
//             ready           - downstream accepts a beat this cycle
//             out_valid       - out_col/out_x/out_y carry a new column
//             out_col         - row k at [k*DATA_W +: DATA_W], row 0 newest
//             out_x, out_y    - position of the row-0 pixel
//             frame_done      - pulse after the last pixel of a frame
//  Revision : 1.0 - initial release
// ============================================================================
module sobel_window_linebuffer #(
  parameter int DATA_W   = 8,
  parameter int IMG_W    = 1920,
  parameter int IMG_H    = 1080,
  parameter int NUM_ROWS = 3,
  parameter int X_W      = $clog2(IMG_W),
  parameter int Y_W      = $clog2(IMG_H)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       fifo_nempty,
  output logic                       fifo_re,
  input  logic [DATA_W-1:0]          fifo_din,
  input  logic                       ready,
  output logic                       out_valid,
  output logic [NUM_ROWS*DATA_W-1:0] out_col,
  output logic [X_W-1:0]             out_x,
  output logic [Y_W-1:0]             out_y,
  output logic                       frame_done
);

  localparam int             NUM_RAMS    = NUM_ROWS - 1;
  localparam logic [X_W-1:0] X_LAST      = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST      = Y_W'(IMG_H - 1);
  localparam logic [Y_W-1:0] Y_FILL_LAST = Y_W'(NUM_ROWS - 2);

  typedef enum logic [0:0] {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                      state_q, state_d;
  logic [X_W-1:0]              x_cnt_q, x_cnt_d;
  logic [Y_W-1:0]              y_cnt_q, y_cnt_d;
  logic                        out_valid_q;
  logic [NUM_ROWS*DATA_W-1:0]  out_col_q, out_col_d;
  logic [X_W-1:0]              out_x_q, out_x_d;
  logic [Y_W-1:0]              out_y_q, out_y_d;
  logic                        frame_done_q;

  logic                        xfer;
  logic                        x_last;
  logic                        frame_last;
  logic                        emit;

  // Line RAM read ports (combinational) and the delayed cascade write port.
  logic [DATA_W-1:0]           rd_data   [NUM_RAMS];
  logic [DATA_W-1:0]           wr_data_q [NUM_RAMS];
  logic [X_W-1:0]              wr_addr_q;
  logic                        wr_en_q;

  // rst_n gates the strobe so nothing is pulled from the FIFO during reset.
  assign xfer       = fifo_nempty & ready & ~clr & rst_n;
  assign fifo_re    = xfer;
  assign x_last     = (x_cnt_q == X_LAST);
  assign frame_last = x_last & (y_cnt_q == Y_LAST);
  assign emit       = xfer & (state_q == ST_RUN);

  // --------------------------------------------------------------------------
  // Geometry counters and fill/run state machine
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    x_cnt_d = x_cnt_q;
    y_cnt_d = y_cnt_q;
    if (clr) begin
      state_d = ST_FILL;
      x_cnt_d = '0;
      y_cnt_d = '0;
    end else if (xfer) begin
      if (x_last) begin
        x_cnt_d = '0;
        y_cnt_d = frame_last ? '0 : y_cnt_q + 1'b1;
      end else begin
        x_cnt_d = x_cnt_q + 1'b1;
      end
      case (state_q)
        // Once the line NUM_ROWS-2 is complete every RAM holds a line of
        // the current frame, so the next transfer can be emitted.
        ST_FILL: if (x_last && (y_cnt_q == Y_FILL_LAST)) state_d = ST_RUN;
        ST_RUN:  if (frame_last) state_d = ST_FILL;
        default: state_d = ST_FILL;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Output column assembly; outputs hold between emitted columns
  // --------------------------------------------------------------------------
  always_comb begin
    out_col_d = out_col_q;
    out_x_d   = out_x_q;
    out_y_d   = out_y_q;
    if (emit) begin
      out_col_d[DATA_W-1:0] = fifo_din;
      for (int k = 1; k < NUM_ROWS; k++) begin
        out_col_d[k*DATA_W +: DATA_W] = rd_data[k-1];
      end
      out_x_d = x_cnt_q;
      out_y_d = y_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      out_valid_q  <= 1'b0;
      out_col_q    <= '0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      frame_done_q <= 1'b0;
      wr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      out_valid_q  <= emit;
      out_col_q    <= out_col_d;
      out_x_q      <= out_x_d;
      out_y_q      <= out_y_d;
      frame_done_q <= xfer & frame_last;
      wr_en_q      <= xfer;
    end
  end

  // --------------------------------------------------------------------------
  // Cascade write path. Each RAM is written one cycle after the transfer, so
  // the read of the same address in the transfer cycle always sees the old
  // (one line older) value, and the next read address never collides with
  // the pending write.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (xfer) begin
      wr_addr_q    <= x_cnt_q;
      wr_data_q[0] <= fifo_din;
      for (int k = 1; k < NUM_RAMS; k++) begin
        wr_data_q[k] <= rd_data[k-1];
      end
    end
  end

  for (genvar k = 0; k < NUM_RAMS; k++) begin : g_line_ram
    logic [DATA_W-1:0] mem [IMG_W];

    always_ff @(posedge clk) begin
      if (wr_en_q) begin
        mem[wr_addr_q] <= wr_data_q[k];
      end
    end

    assign rd_data[k] = mem[x_cnt_q];
  end

  assign out_valid  = out_valid_q;
  assign out_col    = out_col_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire
